// File: rtl/slc3_mem_ctrl_if.sv
// Bus bundle between the SLC-3 RAM controller, its two requesters and the RAM.
interface slc3_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned REQ_ADDR_W = 16;

    // loader side
    logic                  ld_req;
    logic [REQ_ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0]     ld_wdata;
    logic                  ld_done;
    logic                  ld_gnt;
    logic                  init_busy;
    // CPU side
    logic                  cpu_req;
    logic                  cpu_we;
    logic [REQ_ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_ready;
    // RAM side
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_data;
    logic                  ram_wren;
    logic                  ram_rden;
    logic [DATA_W-1:0]     ram_q;

    // requesters and RAM
    modport master (
        output ld_req, ld_addr, ld_wdata, ld_done,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_q,
        input  ld_gnt, init_busy, cpu_rdata, cpu_ready,
        input  ram_addr, ram_data, ram_wren, ram_rden
    );

    // controller
    modport slave (
        input  ld_req, ld_addr, ld_wdata, ld_done,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_q,
        output ld_gnt, init_busy, cpu_rdata, cpu_ready,
        output ram_addr, ram_data, ram_wren, ram_rden
    );
endinterface

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 program RAM sequencer: power-up loader writes first, then CPU request/ready accesses.
module slc3_mem_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic           Clk,
    input  logic           Reset_n,
    slc3_mem_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : 2;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_ld_cap;
    logic              w_cpu_cap;
    logic              w_rd_cap;
    logic              w_ld_gnt;
    logic              w_ram_wren;
    logic              w_ram_rden;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_unused_hi_addr;

    // Upper requester address bits alias into the RAM and are intentionally dropped
    assign w_unused_hi_addr = ^{bus.ld_addr[15:ADDR_W], bus.cpu_addr[15:ADDR_W]};

    // State and read-latency counter register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, capture strobes and RAM/loader controls
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ld_cap    = 1'b0;
        w_cpu_cap   = 1'b0;
        w_rd_cap    = 1'b0;
        w_ld_gnt    = 1'b0;
        w_ram_wren  = 1'b0;
        w_ram_rden  = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_data  = r_wdata;

        unique case (r_state)
            S_LOAD: begin
                w_ld_gnt   = bus.ld_req;
                w_ram_wren = bus.ld_req;
                w_ram_addr = bus.ld_addr[ADDR_W-1:0];
                w_ram_data = bus.ld_wdata;
                w_ld_cap   = bus.ld_req;
                if (bus.ld_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.cpu_req) begin
                    w_cpu_cap   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = bus.cpu_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                w_ram_wren  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_READ: begin
                w_ram_rden = 1'b1;
                if (r_cnt == CNT_W'(RD_LAT)) begin
                    w_rd_cap    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase

        // Reset silences the RAM and loader grant immediately, not at the next edge
        if (!Reset_n) begin
            w_ld_gnt   = 1'b0;
            w_ram_wren = 1'b0;
            w_ram_rden = 1'b0;
            w_ram_addr = '0;
            w_ram_data = '0;
        end
    end

    // Address/data hold registers and read-data capture
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ld_cap) begin
                r_addr  <= bus.ld_addr[ADDR_W-1:0];
                r_wdata <= bus.ld_wdata;
            end else if (w_cpu_cap) begin
                r_addr <= bus.cpu_addr[ADDR_W-1:0];
                if (bus.cpu_we) begin
                    r_wdata <= bus.cpu_wdata;
                end
            end
            if (w_rd_cap) begin
                r_rdata <= bus.ram_q;
            end
        end
    end

    assign bus.ld_gnt    = w_ld_gnt;
    assign bus.init_busy = (r_state == S_LOAD);
    assign bus.cpu_ready = (r_state == S_DONE);
    assign bus.cpu_rdata = r_rdata;
    assign bus.ram_wren  = w_ram_wren;
    assign bus.ram_rden  = w_ram_rden;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_data  = w_ram_data;
endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Self-checking bench for slc3_mem_ctrl with a behavioural registered-read RAM.
module tb_slc3_mem_ctrl;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned MEM_N  = 1 << ADDR_W;

    typedef struct {
        logic              we;
        logic [15:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } vec_t;

    typedef struct {
        logic              is_rd;
        logic [DATA_W-1:0] rdata;
        int                cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    slc3_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    slc3_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // RAM model: write on edge, read data appears RD_LAT edges after address sampled
    logic [DATA_W-1:0] mem [MEM_N];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic              mem_ready = 1'b0;

    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < int'(MEM_N); i++) mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        if (bus.ram_rden) rd_pipe[0] <= mem[bus.ram_addr];
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_q = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cpu_ready must match the oldest expectation
    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n && !bus.init_busy) begin
            n_chk++;
            if (bus.ram_wren && bus.ram_rden) begin
                n_fail++;
                $display("FAIL wren_rden_excl: both high at cycle %0d", cyc);
            end
        end
        if (bus.cpu_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || (e.is_rd && bus.cpu_rdata !== e.rdata)) begin
                    n_fail++;
                    $display("FAIL ready_sb: got cycle %0d rdata %h expected cycle %0d rdata %h",
                             cyc, bus.cpu_rdata, e.cyc, e.rdata);
                end
            end
        end
    end

    task automatic wait_ready(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge Clk);
            if (bus.cpu_ready) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ready_timeout: got no cpu_ready expected one within %0d cycles", budget);
        end
    endtask

    // Issue one CPU access from IDLE; expectation pushed when the request is driven
    task automatic cpu_op(input logic we, input logic [15:0] addr,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
        exp_t e;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        e.is_rd = !we;
        e.rdata = rd;
        e.cyc   = cyc + (we ? 2 : int'(RD_LAT) + 2);
        sb.push_back(e);
        wait_ready(int'(RD_LAT) * 4 + 10);
        @(posedge Clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs [9];
        exp_t              e;
        logic [DATA_W-1:0] last_rd;
        int                L;

        vecs[0] = '{1'b1, 16'h0010, 16'h5555, 16'h0000};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'h5555};
        vecs[2] = '{1'b0, 16'h0410, 16'h0000, 16'h5555};
        vecs[3] = '{1'b1, 16'h03FF, 16'h0F0F, 16'h0000};
        vecs[4] = '{1'b0, 16'h0020, 16'h0000, 16'h0000};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h1234};
        vecs[6] = '{1'b1, 16'h0405, 16'h7777, 16'h0000};
        vecs[7] = '{1'b0, 16'h0005, 16'h0000, 16'h7777};
        vecs[8] = '{1'b0, 16'h03FF, 16'h0000, 16'h0F0F};

        // reset with a loader request pending: everything must stay quiet
        bus.ld_req = 1'b1; bus.ld_addr = 16'h03FF; bus.ld_wdata = 16'hFFFF; bus.ld_done = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        chk("rst_ram_wren", 32'(bus.ram_wren), 32'h0);
        chk("rst_ram_rden", 32'(bus.ram_rden), 32'h0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        chk("rst_ram_data", 32'(bus.ram_data), 32'h0);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'h0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("rst_init_busy", 32'(bus.init_busy), 32'h1);

        // loader writes two words; CPU read to 0x3FF held throughout LOAD
        Reset_n = 1'b1;
        bus.ld_addr = 16'h0000; bus.ld_wdata = 16'h1234;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h03FF;
        #1;
        chk("ld0_gnt", 32'(bus.ld_gnt), 32'h1);
        chk("ld0_wren", 32'(bus.ram_wren), 32'h1);
        chk("ld0_addr", 32'(bus.ram_addr), 32'h000);
        chk("ld0_data", 32'(bus.ram_data), 32'h1234);
        chk("ld0_rden", 32'(bus.ram_rden), 32'h0);
        @(posedge Clk); #1;
        bus.ld_addr = 16'h03FF; bus.ld_wdata = 16'hABCD; bus.ld_done = 1'b1;
        L = cyc;
        e.is_rd = 1'b1; e.rdata = 16'hABCD; e.cyc = L + int'(RD_LAT) + 3;
        sb.push_back(e);
        #1;
        chk("ld1_gnt", 32'(bus.ld_gnt), 32'h1);
        chk("ld1_addr", 32'(bus.ram_addr), 32'h3FF);
        chk("ld1_data", 32'(bus.ram_data), 32'hABCD);
        chk("ld1_rden", 32'(bus.ram_rden), 32'h0);
        chk("ld1_busy", 32'(bus.init_busy), 32'h1);
        @(posedge Clk); #1;
        // loader keeps requesting after done: must be ignored
        bus.ld_done = 1'b0; bus.ld_addr = 16'h0020; bus.ld_wdata = 16'hDEAD;
        #1;
        chk("idle_busy", 32'(bus.init_busy), 32'h0);
        chk("idle_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        chk("idle_wren", 32'(bus.ram_wren), 32'h0);
        chk("mem_0000", 32'(mem[0]), 32'h1234);
        chk("mem_03ff", 32'(mem[10'h3FF]), 32'hABCD);
        wait_ready(int'(RD_LAT) * 4 + 10);
        @(posedge Clk); #1;
        bus.cpu_req = 1'b0;
        chk("held_read_rdata", 32'(bus.cpu_rdata), 32'hABCD);
        last_rd = 16'hABCD;

        // table-driven CPU accesses
        for (int i = 0; i < 9; i++) begin
            cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
            if (!vecs[i].we) last_rd = vecs[i].rdata;
            chk("vec_rdata_hold", 32'(bus.cpu_rdata), 32'(last_rd));
            chk("vec_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        end

        // aliased read drives the truncated RAM address
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0410;
        e.is_rd = 1'b1; e.rdata = 16'h5555; e.cyc = cyc + int'(RD_LAT) + 2;
        sb.push_back(e);
        @(posedge Clk); #1;
        chk("alias_ram_addr", 32'(bus.ram_addr), 32'h010);
        chk("alias_rden", 32'(bus.ram_rden), 32'h1);
        chk("alias_wren", 32'(bus.ram_wren), 32'h0);
        wait_ready(int'(RD_LAT) * 4 + 10);
        @(posedge Clk); #1;
        bus.cpu_req = 1'b0;

        // reset in the middle of a read: abandoned, never acknowledged
        bus.ld_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
        @(posedge Clk); #1;
        chk("mid_read_rden", 32'(bus.ram_rden), 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_rden", 32'(bus.ram_rden), 32'h0);
        chk("arst_addr", 32'(bus.ram_addr), 32'h0);
        chk("arst_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("arst_ready", 32'(bus.cpu_ready), 32'h0);
        chk("arst_busy", 32'(bus.init_busy), 32'h1);
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        bus.ld_req = 1'b1; bus.ld_addr = 16'h0030; bus.ld_wdata = 16'hBEEF;
        #1;
        chk("reload_gnt", 32'(bus.ld_gnt), 32'h1);
        chk("reload_addr", 32'(bus.ram_addr), 32'h030);
        @(posedge Clk); #1;
        bus.ld_req = 1'b0; bus.ld_done = 1'b1;
        @(posedge Clk); #1;
        bus.ld_done = 1'b0;
        chk("reload_busy", 32'(bus.init_busy), 32'h0);
        repeat (int'(RD_LAT) + 4) @(posedge Clk);
        #1;
        cpu_op(1'b0, 16'h0030, 16'h0000, 16'hBEEF);

        // continuously held request: three reads, RD_LAT+3 cycles apart
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        for (int k = 0; k < 3; k++) begin
            e.is_rd = 1'b1; e.rdata = 16'h5555;
            e.cyc = cyc + int'(RD_LAT) + 2 + k * (int'(RD_LAT) + 3);
            sb.push_back(e);
        end
        for (int k = 0; k < 3; k++) wait_ready(int'(RD_LAT) * 4 + 10);
        @(posedge Clk); #1;
        bus.cpu_req = 1'b0;
        repeat (int'(RD_LAT) + 6) @(posedge Clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
